// File: rtl/bd_tap_pkg.sv
// Shared types, constants and helpers for the PC<->BD traffic tap.
package bd_tap_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_e;

  typedef enum logic {
    SRC_CORE,
    SRC_BD
  } src_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Operands are zero-extended by the caller, so any code width up to 64 bits works.
  function automatic logic code_match(input logic [63:0] code,
                                      input logic [63:0] ref_code,
                                      input logic [63:0] mask);
    return ((code ^ ref_code) & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/bd_tap_if.sv
// Valid/ready channel: a word moves on a rising clock edge when v and a are both high.
interface bd_tap_if #(
  parameter int W = 32
) ();
  logic         v;
  logic         a;
  logic [W-1:0] d;

  modport master (output v, output d, input a);
  modport slave  (input v, input d, output a);
endinterface

// File: rtl/bd_tap_deser.sv
// Collects NPCdata-wide words (LSBs first) into one NBDin-wide word and holds it until taken.
module bd_tap_deser
  import bd_tap_pkg::*;
#(
  parameter int NPCdata = 24,
  parameter int NBDin   = 34
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic [NPCdata-1:0] i_data,
  output logic               o_ready,
  output logic               o_valid,
  output logic [NBDin-1:0]   o_data,
  input  logic               i_ready
);

  localparam int NIN     = ceil_div(NBDin, NPCdata);
  localparam int IDX_W   = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int SHIFT_W = NIN * NPCdata;

  logic [IDX_W-1:0]   r_idx;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_valid;
  logic [NBDin-1:0]   r_data;
  logic [SHIFT_W-1:0] w_merge;
  logic               w_accept;
  logic               w_last;

  assign o_ready  = !r_valid;
  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign w_accept = i_valid && o_ready;
  assign w_last   = (r_idx == IDX_W'(NIN - 1));

  always_comb begin
    w_merge = r_shift;
    w_merge[r_idx*NPCdata +: NPCdata] = i_data;
  end

  // Bits of the last word above NBDin fall away when the merged word is truncated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_accept) begin
        r_shift <= w_merge;
        r_idx   <= w_last ? '0 : r_idx + 1'b1;
      end
      if (w_accept && w_last) begin
        r_valid <= 1'b1;
        r_data  <= w_merge[NBDin-1:0];
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bd_tap_harness.sv
// PC<->BD traffic tap between the host channels and a Core instance.
// Define BD_TAP_COUNT_EN to implement the saturating packet counters.
module bd_tap_harness
  import bd_tap_pkg::*;
#(
  parameter int                  NPCcode    = 8,
  parameter int                  NPCdata    = 24,
  parameter int                  NBDin      = 34,
  parameter int                  NBDout     = 21,
  parameter logic [NPCcode-1:0]  CodeMask   = '1,
  parameter logic [NPCcode-1:0]  PCtoBDcode = '1,
  parameter logic [NPCcode-1:0]  BDtoPCcode = '1
) (
  input  logic               clk,
  input  logic               reset,
  bd_tap_if.slave            pc_in,
  bd_tap_if.master           pc_out,
  bd_tap_if.master           core_pc_in,
  bd_tap_if.slave            core_pc_out,
  bd_tap_if.slave            core_bd_out,
  bd_tap_if.master           core_bd_in,
  output logic [COUNT_W-1:0] bd_in_count,
  output logic [COUNT_W-1:0] bd_out_count
);

  localparam int NPCword = NPCcode + NPCdata;
  localparam int NOUT    = ceil_div(NBDout, NPCdata);
  localparam int SER_W   = NOUT * NPCdata;
  localparam int SIDX_W  = (NOUT > 1) ? $clog2(NOUT) : 1;

  logic w_match;
  logic w_deser_valid;
  logic w_deser_ready;

  assign w_match = code_match(64'(pc_in.d[NPCword-1:NPCdata]), 64'(PCtoBDcode), 64'(CodeMask));
  assign core_pc_in.v  = pc_in.v && !w_match;
  assign core_pc_in.d  = pc_in.d;
  assign w_deser_valid = pc_in.v && w_match;
  assign pc_in.a       = w_match ? w_deser_ready : core_pc_in.a;

  bd_tap_deser #(
    .NPCdata (NPCdata),
    .NBDin   (NBDin)
  ) u_deser (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_deser_valid),
    .i_data  (pc_in.d[NPCdata-1:0]),
    .o_ready (w_deser_ready),
    .o_valid (core_bd_in.v),
    .o_data  (core_bd_in.d),
    .i_ready (core_bd_in.a)
  );

  ser_state_e          r_ser_state;
  ser_state_e          w_ser_next;
  logic [SER_W-1:0]    r_ser_data;
  logic [SIDX_W-1:0]   r_ser_idx;
  logic                w_ser_valid;
  logic                w_ser_ready;
  logic                w_ser_xfer;
  logic                w_ser_last;
  logic                w_bd_accept;
  logic [NPCword-1:0]  w_ser_word;

  assign w_ser_last  = (r_ser_idx == SIDX_W'(NOUT - 1));
  assign w_ser_xfer  = w_ser_valid && w_ser_ready;
  assign w_bd_accept = core_bd_out.v && core_bd_out.a;
  assign w_ser_word  = {BDtoPCcode, r_ser_data[r_ser_idx*NPCdata +: NPCdata]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ser_state <= SER_IDLE;
    else        r_ser_state <= w_ser_next;
  end

  always_comb begin
    w_ser_next    = r_ser_state;
    core_bd_out.a = 1'b0;
    w_ser_valid   = 1'b0;
    unique case (r_ser_state)
      SER_IDLE: begin
        core_bd_out.a = 1'b1;
        if (core_bd_out.v) w_ser_next = SER_SEND;
      end
      SER_SEND: begin
        w_ser_valid = 1'b1;
        if (w_ser_xfer && w_ser_last) w_ser_next = SER_IDLE;
      end
    endcase
  end

  // The captured word is zero-extended so padding above NBDout goes out as zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ser_data <= '0;
      r_ser_idx  <= '0;
    end else if (w_bd_accept) begin
      r_ser_data <= SER_W'(core_bd_out.d);
      r_ser_idx  <= '0;
    end else if (w_ser_xfer && !w_ser_last) begin
      r_ser_idx  <= r_ser_idx + 1'b1;
    end
  end

  src_e r_prio;
  logic r_lock;
  logic w_grant_bd;
  logic w_core_xfer;

  always_comb begin
    w_grant_bd = 1'b0;
    if (r_lock)                          w_grant_bd = 1'b1;
    else if (core_pc_out.v && w_ser_valid) w_grant_bd = (r_prio == SRC_BD);
    else                                 w_grant_bd = w_ser_valid && !core_pc_out.v;
  end

  assign pc_out.v      = w_grant_bd ? w_ser_valid : core_pc_out.v;
  assign pc_out.d      = w_grant_bd ? w_ser_word  : core_pc_out.d;
  assign core_pc_out.a = !w_grant_bd && pc_out.a;
  assign w_ser_ready   = w_grant_bd && pc_out.a;
  assign w_core_xfer   = core_pc_out.v && core_pc_out.a;

  // A BD packet keeps the grant from its first word to its last so packets never interleave.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio <= SRC_CORE;
      r_lock <= 1'b0;
    end else if (w_core_xfer) begin
      r_prio <= SRC_BD;
    end else if (w_ser_xfer) begin
      r_lock <= !w_ser_last;
      if (w_ser_last) r_prio <= SRC_CORE;
    end
  end

`ifdef BD_TAP_COUNT_EN
  logic [COUNT_W-1:0] r_in_cnt;
  logic [COUNT_W-1:0] r_out_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (core_bd_in.v && core_bd_in.a && (r_in_cnt != '1)) r_in_cnt <= r_in_cnt + 1'b1;
      if (w_ser_xfer && w_ser_last && (r_out_cnt != '1))    r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  assign bd_in_count  = r_in_cnt;
  assign bd_out_count = r_out_cnt;
`else
  assign bd_in_count  = '0;
  assign bd_out_count = '0;
`endif

endmodule

// File: doc/bd_tap_harness.md
# bd_tap_harness

Parametrised PC↔BD traffic tap placed between the PC-side channels and a `Core` instance, so the host can inject simulated BD traffic and observe everything the core sends toward BD. PC-to-BD words are selected by a masked code match and deserialized into an arbitrary-width BD input word. Arbitrary-width BD output words are serialized into one or more coded PC words and merged fairly with core upstream traffic, without interleaving multi-word packets. The parent instantiates `Core` and connects it to the `core_*` ports.

## Interface
- NPCcode, 8, code field width of a PC word
- NPCdata, 24, payload field width of a PC word; NPCword = NPCcode+NPCdata
- NBDin, 34, width of core BD input word
- NBDout, 21, width of core BD output word
- CodeMask, all ones (NPCcode bits), bits of the code field compared by the split
- PCtoBDcode, all ones (NPCcode bits), code selecting PC→BD traffic
- BDtoPCcode, all ones (NPCcode bits), code stamped on every serialized BD word
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- pc_in  Channel  NPCword  host downstream traffic
- pc_out  Channel  NPCword  host upstream traffic
- core_pc_in  Channel  NPCword  to core PC input
- core_pc_out  Channel  NPCword  from core PC output
- core_bd_out  Channel  NBDout  from core BD output
- core_bd_in  Channel  NBDin  to core BD input
- bd_in_count  output  16  BD input packets delivered
- bd_out_count  output  16  BD output packets fully sent

## Operation
- Handshake: a transfer occurs on a rising clk edge with v=1 and a=1. v must not drop and d must not change until the transfer completes.
- Split (combinational): match = ((pc_in.d[NPCword-1:NPCdata] ^ PCtoBDcode) & CodeMask) == 0.
  - Match: word goes to the deserializer.
  - No match: word goes to core_pc_in.
  - pc_in.a equals the selected destination's ready; the unselected destination sees v=0.
- Deserializer: NIN = ceil(NBDin/NPCdata) words per packet, first word supplies the LSBs.
  - Index counter runs 0..NIN-1. Each accepted word is written into the shift register at offset idx*NPCdata.
  - Bits at or above NBDin in the last word are discarded.
  - On acceptance of the last word, core_bd_in.v is set on the next cycle and held until the transfer. While it is held, the deserializer ready is 0.
- Serializer: NOUT = ceil(NBDout/NPCdata) words per packet.
  - States IDLE and SEND.
  - IDLE: core_bd_out.a=1. On transfer, capture d, set idx=0, go to SEND.
  - SEND: present {BDtoPCcode, payload slice idx, zero-padded above NBDout}. Advance idx on transfer; after word NOUT-1, return to IDLE.
- Merge: round-robin between core_pc_out and the serializer.
  - A BD packet, once its first word is granted, holds the grant until its last word.
  - Priority toggles to the other source after each completed core word or BD packet.
  - The non-granted source sees a=0.
- Counters: 16-bit, saturating at 0xFFFF.
  - bd_in_count increments on a core_bd_in transfer.
  - bd_out_count increments on a transfer of the last serialized word.

## Timing
- Reset values:
  - core_bd_in.v=0, serializer in IDLE, deser idx=0, ser idx=0.
  - Priority is core_pc_out first; no grant lock.
  - Counters=0.
  - pc_out.v and core_pc_in.v are 0 unless their source is valid.
- Core path: zero-latency combinational in both directions (pc_in→core_pc_in, core_pc_out→pc_out).
- BD input: core_bd_in.v rises 1 cycle after the last word's transfer. Throughput is 1 packet per NIN+1 cycles minimum.
- BD output: first word is valid on pc_out 1 cycle after the core_bd_out transfer. Subsequent words follow 1 per cycle while pc_out.a=1.
- Simultaneous valid on both merge sources: the source with priority wins. A locked BD packet overrides priority.
- Reset mid-operation: partially received or sent packets are discarded and counters cleared; no partial word is emitted after release.

## Configuration
- BD_TAP_COUNT_EN defined: counters are implemented as described.
- BD_TAP_COUNT_EN undefined: no counter flops; bd_in_count and bd_out_count are tied to 0. The ports remain.

## Structure
- Package bd_tap_pkg holds:
  - function ceil_div(a,b);
  - function code_match(code, ref, mask);
  - constant COUNT_W=16.
- One sub-module: bd_tap_deser (generic NPCdata→NBDin deserializer with index counter and output hold register).
- Split, serializer FSM, arbiter and counters are inline.

## Test plan
- pc_in 32'hFF123456 then 32'hFF00000A → one core_bd_in transfer with d=34'h00A123456; bd_in_count=1.
- pc_in 32'h03000001 → core_pc_in.d=32'h03000001 in the same cycle; deserializer untouched; core_bd_in.v stays 0.
- core_bd_out.d=21'h1ABCDE with pc_out.a=1 → pc_out.d=32'hFF1ABCDE one cycle later; bd_out_count=1.
- core_pc_out and the BD stream both continuously valid (defaults) → pc_out alternates core, BD, core, BD, starting with core after reset.
- NBDout=40, core_bd_out.d=40'hABCDEF0123, core_pc_out valid throughout → pc_out carries 32'hFFEF0123 then 32'hFF00ABCD back-to-back, with no core word between them.
- First BD-in word accepted, reset pulsed low, then words 32'hFF000001 and 32'hFF000000 → exactly one core_bd_in transfer with d=34'h1; count=1.
